// File: rtl/pwm_multi_bus.sv
// Multi-channel PWM peripheral on the picorv32 native memory bus.
// Period/duty are double-buffered and take effect at a period boundary; invert applies at once.
module pwm_multi_bus #(
  parameter int          NCH   = 2,
  parameter int          CNT_W = 16,
  parameter logic [31:0] BASE  = 32'h8000_0100
) (
  input  logic             sys_clk,
  input  logic             sys_resetn,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic [NCH-1:0]   pwm_out,
  output logic             irq_wrap
);

  typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] res;
    res = 32'd0;
    res[CNT_W-1:0] = v;
    return res;
  endfunction

  function automatic logic [31:0] zext_ch(input logic [NCH-1:0] v);
    logic [31:0] res;
    res = 32'd0;
    res[NCH-1:0] = v;
    return res;
  endfunction

  logic             gen_en_r, gen_en_s, ready_r, irq_r, irq_s, sel_s, tick_s;
  logic [7:0]       presc_r, presc_s, presc_cnt_r, presc_cnt_s, off_s;
  logic [NCH-1:0]   status_r, status_s, irq_en_r, irq_en_s, ch_en_r, ch_en_s, inv_r, inv_s;
  logic [NCH-1:0]   w1c_s, wrap_s, pwm_r, pwm_s;
  logic [31:0]      rdata_r, rdata_s, m_s;
  logic [CNT_W-1:0] per_sh_r [NCH], per_sh_s [NCH], duty_sh_r [NCH], duty_sh_s [NCH];
  logic [CNT_W-1:0] per_act_r [NCH], per_act_s [NCH], duty_act_r [NCH], duty_act_s [NCH];
  logic [CNT_W-1:0] cnt_r [NCH], cnt_s [NCH];
  ch_state_t        state_r [NCH], state_s [NCH];

  assign off_s = mem_addr[7:0];
  assign sel_s = mem_valid && (mem_addr[31:8] == BASE[31:8]) && !ready_r;

  // Register decode: read mux and byte-strobed shadow updates (a read has wstrb=0, so nothing changes)
  always_comb begin
    gen_en_s  = gen_en_r;
    presc_s   = presc_r;
    irq_en_s  = irq_en_r;
    ch_en_s   = ch_en_r;
    inv_s     = inv_r;
    per_sh_s  = per_sh_r;
    duty_sh_s = duty_sh_r;
    w1c_s     = '0;
    rdata_s   = 32'd0;
    m_s       = 32'd0;
    if (sel_s) begin
      case (off_s)
        8'h00: begin
          rdata_s  = {16'd0, presc_r, 7'd0, gen_en_r};
          m_s      = merge_bytes(rdata_s, mem_wdata, mem_wstrb);
          gen_en_s = m_s[0];
          presc_s  = m_s[15:8];
        end
        8'h04: begin
          rdata_s = zext_ch(status_r);
          w1c_s   = mem_wstrb[0] ? mem_wdata[NCH-1:0] : '0;
        end
        8'h08: begin
          rdata_s  = zext_ch(irq_en_r);
          m_s      = merge_bytes(rdata_s, mem_wdata, mem_wstrb);
          irq_en_s = m_s[NCH-1:0];
        end
        default: begin
          for (int i = 0; i < NCH; i++) begin
            case ({off_s[7:4] == 4'(i + 1), off_s[3:0]})
              5'h10: begin
                rdata_s     = zext_cnt(per_sh_r[i]);
                m_s         = merge_bytes(rdata_s, mem_wdata, mem_wstrb);
                per_sh_s[i] = m_s[CNT_W-1:0];
              end
              5'h14: begin
                rdata_s      = zext_cnt(duty_sh_r[i]);
                m_s          = merge_bytes(rdata_s, mem_wdata, mem_wstrb);
                duty_sh_s[i] = m_s[CNT_W-1:0];
              end
              5'h18: begin
                rdata_s    = {30'd0, inv_r[i], ch_en_r[i]};
                m_s        = merge_bytes(rdata_s, mem_wdata, mem_wstrb);
                ch_en_s[i] = m_s[0];
                inv_s[i]   = m_s[1];
              end
              default: ;
            endcase
          end
        end
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign tick_s      = gen_en_r && (presc_cnt_r == presc_r);
  assign presc_cnt_s = (!gen_en_r || tick_s) ? 8'd0 : presc_cnt_r + 8'd1;

  // Per-channel IDLE/RUN next state; shadows loaded on entry and at wrap include a same-edge write
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    per_act_s  = per_act_r;
    duty_act_s = duty_act_r;
    wrap_s     = '0;
    pwm_s      = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_s[i] = ((state_r[i] == CH_RUN) && (cnt_r[i] < duty_act_r[i])) ^ inv_r[i];
      case (state_r[i])
        CH_IDLE: begin
          cnt_s[i] = '0;
          if (gen_en_r && ch_en_r[i]) begin
            state_s[i]    = CH_RUN;
            per_act_s[i]  = per_sh_s[i];
            duty_act_s[i] = duty_sh_s[i];
          end else begin
            state_s[i] = CH_IDLE;
          end
        end
        CH_RUN: begin
          if (!(gen_en_r && ch_en_r[i])) begin
            state_s[i] = CH_IDLE;
            cnt_s[i]   = '0;
          end else if (tick_s && (cnt_r[i] == per_act_r[i])) begin
            cnt_s[i]      = '0;
            per_act_s[i]  = per_sh_s[i];
            duty_act_s[i] = duty_sh_s[i];
            wrap_s[i]     = 1'b1;
          end else if (tick_s) begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1);
          end else begin
            cnt_s[i] = cnt_r[i];
          end
        end
        default: begin
          state_s[i] = CH_IDLE;
          cnt_s[i]   = '0;
        end
      endcase
    end
  end

  // A hardware wrap outranks a same-edge clear
  assign status_s = (status_r & ~w1c_s) | wrap_s;
  assign irq_s    = |(status_s & irq_en_s);

  // State registers
  always_ff @(posedge sys_clk) begin
    if (!sys_resetn) begin
      gen_en_r    <= 1'b0;
      presc_r     <= 8'd0;
      presc_cnt_r <= 8'd0;
      status_r    <= '0;
      irq_en_r    <= '0;
      ch_en_r     <= '0;
      inv_r       <= '0;
      pwm_r       <= '0;
      ready_r     <= 1'b0;
      rdata_r     <= 32'd0;
      irq_r       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        per_sh_r[i]   <= '0;
        duty_sh_r[i]  <= '0;
        per_act_r[i]  <= '0;
        duty_act_r[i] <= '0;
        cnt_r[i]      <= '0;
        state_r[i]    <= CH_IDLE;
      end
    end else begin
      gen_en_r    <= gen_en_s;
      presc_r     <= presc_s;
      presc_cnt_r <= presc_cnt_s;
      status_r    <= status_s;
      irq_en_r    <= irq_en_s;
      ch_en_r     <= ch_en_s;
      inv_r       <= inv_s;
      pwm_r       <= pwm_s;
      ready_r     <= sel_s;
      rdata_r     <= rdata_s;
      irq_r       <= irq_s;
      per_sh_r    <= per_sh_s;
      duty_sh_r   <= duty_sh_s;
      per_act_r   <= per_act_s;
      duty_act_r  <= duty_act_s;
      cnt_r       <= cnt_s;
      state_r     <= state_s;
    end
  end

  assign mem_ready = ready_r;
  assign mem_rdata = rdata_r;
  assign pwm_out   = pwm_r;
  assign irq_wrap  = irq_r;

endmodule

// File: tb/tb_pwm_multi_bus.sv
// Bench for pwm_multi_bus: directed scenarios plus randomized bus traffic,
// every cycle compared against a period-position reference model.
module tb_pwm_multi_bus;
  localparam int          NCH  = 2;
  localparam logic [31:0] BASE = 32'h8000_0100;

  logic           sys_clk = 1'b0, sys_resetn = 1'b0, mem_valid = 1'b0;
  logic [31:0]    mem_addr = 32'd0, mem_wdata = 32'd0;
  logic [3:0]     mem_wstrb = 4'd0;
  logic           mem_ready, irq_wrap;
  logic [31:0]    mem_rdata;
  logic [NCH-1:0] pwm_out;

  always #10 sys_clk = ~sys_clk;

  pwm_multi_bus #(.NCH(NCH), .CNT_W(16), .BASE(BASE)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pwm_out(pwm_out), .irq_wrap(irq_wrap));

  int n_tests = 0, n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // Reference model: each channel tracks its position within the current period in prescaled ticks
  bit             m_gen, m_ready, m_irq;
  int             m_presc, m_pc;
  bit [NCH-1:0]   m_status, m_irqen, m_en, m_inv, m_run, m_pwm;
  int             m_per_sh[NCH], m_duty_sh[NCH], m_per[NCH], m_duty[NCH], m_pos[NCH];
  logic [31:0]    m_rdata;

  always @(posedge sys_clk) begin : ref_model
    logic [31:0] rd, w;
    bit sel, tick, n_gen;
    bit [NCH-1:0] w1c, setf, n_irqen, n_en, n_inv;
    int a, c, n_presc, n_per_sh[NCH], n_duty_sh[NCH];
    if (!sys_resetn) begin
      m_gen = 0; m_ready = 0; m_irq = 0; m_presc = 0; m_pc = 0; m_status = 0; m_irqen = 0;
      m_en = 0; m_inv = 0; m_run = 0; m_pwm = 0; m_rdata = 32'd0;
      for (int i = 0; i < NCH; i++) begin
        m_per_sh[i] = 0; m_duty_sh[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_pos[i] = 0;
      end
    end else begin
      sel = mem_valid && (mem_addr[31:8] == BASE[31:8]) && !m_ready;
      n_gen = m_gen; n_presc = m_presc; n_irqen = m_irqen; n_en = m_en; n_inv = m_inv;
      n_per_sh = m_per_sh; n_duty_sh = m_duty_sh;
      rd = 32'd0; w1c = 0; setf = 0;
      if (sel) begin
        a = int'(mem_addr[7:0]);
        if (a == 0) begin
          rd = (m_presc << 8) | int'(m_gen);
          w = bmerge(rd, mem_wdata, mem_wstrb); n_gen = w[0]; n_presc = int'(w[15:8]);
        end else if (a == 4) begin
          rd = 32'(m_status);
          if (mem_wstrb[0]) w1c = mem_wdata[NCH-1:0];
        end else if (a == 8) begin
          rd = 32'(m_irqen);
          w = bmerge(rd, mem_wdata, mem_wstrb); n_irqen = w[NCH-1:0];
        end else if (a >= 16 && a < 16 * (NCH + 1)) begin
          c = a / 16 - 1;
          if (a % 16 == 0) begin
            rd = m_per_sh[c]; w = bmerge(rd, mem_wdata, mem_wstrb); n_per_sh[c] = int'(w[15:0]);
          end else if (a % 16 == 4) begin
            rd = m_duty_sh[c]; w = bmerge(rd, mem_wdata, mem_wstrb); n_duty_sh[c] = int'(w[15:0]);
          end else if (a % 16 == 8) begin
            rd = {m_inv[c], m_en[c]}; w = bmerge(rd, mem_wdata, mem_wstrb); n_en[c] = w[0]; n_inv[c] = w[1];
          end
        end
      end
      tick = m_gen && (m_pc == m_presc);
      m_pc = (!m_gen || tick) ? 0 : m_pc + 1;
      for (int i = 0; i < NCH; i++) begin
        m_pwm[i] = (m_run[i] && (m_pos[i] < m_duty[i])) ^ m_inv[i];
        if (!(m_gen && m_en[i])) begin
          m_run[i] = 0; m_pos[i] = 0;
        end else if (!m_run[i]) begin
          m_run[i] = 1; m_pos[i] = 0; m_per[i] = n_per_sh[i]; m_duty[i] = n_duty_sh[i];
        end else if (tick) begin
          if (m_pos[i] == m_per[i]) begin
            m_pos[i] = 0; m_per[i] = n_per_sh[i]; m_duty[i] = n_duty_sh[i]; setf[i] = 1;
          end else begin
            m_pos[i] = m_pos[i] + 1;
          end
        end
      end
      m_status = (m_status & ~w1c) | setf;
      m_gen = n_gen; m_presc = n_presc; m_irqen = n_irqen; m_en = n_en; m_inv = n_inv;
      m_per_sh = n_per_sh; m_duty_sh = n_duty_sh;
      m_irq = |(m_status & m_irqen);
      m_ready = sel;
      m_rdata = sel ? rd : 32'd0;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge sys_clk) begin
    if (chk_on) begin
      check_val("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check_val("irq_wrap", 32'(irq_wrap), 32'(m_irq));
      check_val("mem_ready", 32'(mem_ready), 32'(m_ready));
      if (m_ready) check_val("mem_rdata", mem_rdata, m_rdata);
    end
  end

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     output logic [31:0] rdata);
    bit got;
    @(negedge sys_clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    got = 1'b0; rdata = 32'd0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge sys_clk);
      if (mem_ready) begin got = 1'b1; rdata = mem_rdata; end
    end
    if (!got) check_val("bus_timeout", 32'd0, 32'd1);
    mem_valid = 1'b0; mem_wstrb = 4'd0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    bus(BASE + 32'(off), d, 4'hF, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus(BASE + 32'(off), 32'd0, 4'h0, v);
    check_val(tag, v, exp);
  endtask

  task automatic count_high(input int ch, input int settle, input int n, output int cnt);
    cnt = 0;
    repeat (settle) @(negedge sys_clk);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      cnt += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] v;
    int presc_fix;
    repeat (3) @(posedge sys_clk);
    chk_on = 1'b1;
    @(negedge sys_clk);
    check_val("rst_pwm", 32'(pwm_out), 32'd0);
    check_val("rst_ready", 32'(mem_ready), 32'd0);
    check_val("rst_rdata", mem_rdata, 32'd0);
    check_val("rst_irq", 32'(irq_wrap), 32'd0);
    sys_resetn = 1'b1;

    // T1: 3 high / 7 low
    wr(8'h10, 32'd9); wr(8'h14, 32'd3); wr(8'h18, 32'd1); wr(8'h00, 32'h0000_0001);
    count_high(0, 25, 20, cnt);
    check_val("t1_high", 32'(cnt), 32'd6);
    rd_chk("t1_status", 8'h04, 32'd1);
    // T2: buffered duty change, immediate readback
    wr(8'h14, 32'd7);
    rd_chk("t2_duty_rb", 8'h14, 32'd7);
    count_high(0, 25, 20, cnt);
    check_val("t2_high", 32'(cnt), 32'd14);
    // T3: duty boundaries and invert
    wr(8'h14, 32'd0);  count_high(0, 25, 20, cnt); check_val("t3_duty0", 32'(cnt), 32'd0);
    wr(8'h14, 32'd12); count_high(0, 25, 20, cnt); check_val("t3_duty_gt", 32'(cnt), 32'd20);
    wr(8'h10, 32'd0); wr(8'h14, 32'd1); count_high(0, 25, 20, cnt); check_val("t3_per0", 32'(cnt), 32'd20);
    wr(8'h18, 32'd3);  count_high(0, 3, 20, cnt);  check_val("t3_inv", 32'(cnt), 32'd0);
    // T4: prescaled 10/10, then global disable
    wr(8'h18, 32'd1); wr(8'h00, 32'h0000_0401); wr(8'h10, 32'd3); wr(8'h14, 32'd2);
    count_high(0, 50, 40, cnt);
    check_val("t4_high", 32'(cnt), 32'd20);
    wr(8'h28, 32'd2); wr(8'h00, 32'd0);
    repeat (3) @(negedge sys_clk);
    check_val("t4_gdis", 32'(pwm_out), 32'b10);
    // T5: bus corner cases
    rd_chk("t5_unmapped", 8'h0C, 32'd0);
    rd_chk("t5_unaligned", 8'h11, 32'd0);
    rd_chk("t5_beyond_nch", 8'h30, 32'd0);
    wr(8'h10, 32'h0000_1234);
    bus(BASE + 32'h10, 32'hFFFF_FFAB, 4'b0001, v);
    rd_chk("t5_wstrb", 8'h10, 32'h0000_12AB);
    wr(8'h10, 32'hFFFF_FFFF);
    rd_chk("t5_upper", 8'h10, 32'h0000_FFFF);
    rd_chk("t5_gctrl", 8'h00, 32'd0);
    wr(8'h10, 32'd0); wr(8'h14, 32'd1); wr(8'h28, 32'd0); wr(8'h00, 32'd1);
    wr(8'h04, 32'd1);
    rd_chk("t5_w1c_setwins", 8'h04, 32'd1);
    wr(8'h08, 32'd1);
    @(negedge sys_clk);
    check_val("t5_irq", 32'(irq_wrap), 32'd1);
    wr(8'h18, 32'd0); wr(8'h04, 32'd3);
    rd_chk("t5_w1c", 8'h04, 32'd0);
    check_val("t5_irq_clr", 32'(irq_wrap), 32'd0);
    mem_valid = 1'b1; mem_addr = BASE + 32'h200; mem_wstrb = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      check_val("t5_outside", 32'(mem_ready), 32'd0);
    end
    mem_valid = 1'b0;

    // Randomized traffic with a fixed prescaler
    presc_fix = $urandom_range(0, 2);
    wr(8'h00, 32'(presc_fix << 8));
    for (int it = 0; it < 400; it++) begin
      int op, ch, reg_sel;
      logic [7:0] off;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NCH - 1);
      reg_sel = $urandom_range(0, 2);
      off = 8'(16 * (ch + 1) + 4 * reg_sel);
      if (op <= 3) begin
        if (reg_sel == 2) d = 32'($urandom_range(0, 3));
        else d = 32'($urandom_range(0, 14)) | (32'($urandom) & 32'hFFFF_0000);
        bus(BASE + 32'(off), d, 4'($urandom_range(0, 15)) | 4'b0001, v);
      end else if (op == 4) begin
        wr(8'h00, 32'(presc_fix << 8) | 32'($urandom_range(0, 1)));
      end else if (op == 5) begin
        bus(BASE + 32'h04, 32'($urandom_range(0, 3)), 4'b0001, v);
      end else if (op == 6) begin
        wr(8'h08, 32'($urandom_range(0, 3)));
      end else if (op == 7) begin
        bus(BASE + 32'($urandom_range(0, 255)), 32'd0, 4'd0, v);
      end else begin
        repeat ($urandom_range(1, 30)) @(negedge sys_clk);
      end
    end

    // T6: reset mid-run with a pending read
    wr(8'h00, 32'd1); wr(8'h10, 32'd5); wr(8'h14, 32'd3); wr(8'h18, 32'd1); wr(8'h08, 32'd1);
    repeat (20) @(negedge sys_clk);
    mem_valid = 1'b1; mem_addr = BASE + 32'h10; mem_wstrb = 4'd0; sys_resetn = 1'b0;
    @(negedge sys_clk);
    check_val("t6_pwm", 32'(pwm_out), 32'd0);
    check_val("t6_ready", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
    @(negedge sys_clk);
    sys_resetn = 1'b1;
    rd_chk("t6_gctrl", 8'h00, 32'd0);
    rd_chk("t6_status", 8'h04, 32'd0);
    rd_chk("t6_irqen", 8'h08, 32'd0);
    rd_chk("t6_per0", 8'h10, 32'd0);
    rd_chk("t6_duty0", 8'h14, 32'd0);
    rd_chk("t6_cctrl0", 8'h18, 32'd0);
    repeat (3) @(negedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
